generation_sequencer: RTL

//  Scan sequencer directly upstream of data_path: walks every pixel of one Conway generation, drives 9-bank

---
 rtl/conway_pkg.sv | 16 +
 rtl/neighbourhood_addr_gen.sv | 37 +++
 rtl/generation_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conway_pkg.sv
// Shared types and pixel-to-bank mapping for the Conway engine. A pixel lands in one of
// nine banks by its position inside a 3x3 block; the block index gives the address.
package conway_pkg;
  localparam int PIXELS_PER_BLOCK = 3;
  localparam int NUM_BANKS        = 9;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, SWAP} state_e;

  function automatic logic [3:0] pixel_bank(input int x, input int y);
    return 4'((y % PIXELS_PER_BLOCK) * PIXELS_PER_BLOCK + (x % PIXELS_PER_BLOCK));
  endfunction

  function automatic int pixel_addr(input int x, input int y, input int width_blocks);
    return (y / PIXELS_PER_BLOCK) * width_blocks + (x / PIXELS_PER_BLOCK);
  endfunction
endpackage

// File: rtl/neighbourhood_addr_gen.sv
// Combinational: pixel (x,y) -> the address each of the nine banks must read so the whole
// toroidal 3x3 window comes back at once, plus the centre pixel's bank and address.
module neighbourhood_addr_gen
  import conway_pkg::*;
#(
  parameter int WIDTH_PIXELS  = 6,
  parameter int HEIGHT_PIXELS = 6,
  parameter int WIDTH_BLOCKS  = 2,
  parameter int ADDR_WIDTH    = 2,
  parameter int XW            = 3,
  parameter int YW            = 3
) (
  input  logic [XW-1:0]                          x,
  input  logic [YW-1:0]                          y,
  output logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]   bank_addr,
  output logic [NUM_BANKS-1:0]                   center_onehot,
  output logic [ADDR_WIDTH-1:0]                  center_addr
);
  always_comb begin
    int xs [3];
    int ys [3];
    xs[1] = int'(x);
    ys[1] = int'(y);
    // Edge wrap done by compare so no divider is needed on the counters.
    xs[0] = (x == '0) ? WIDTH_PIXELS - 1 : int'(x) - 1;
    xs[2] = (int'(x) == WIDTH_PIXELS - 1) ? 0 : int'(x) + 1;
    ys[0] = (y == '0) ? HEIGHT_PIXELS - 1 : int'(y) - 1;
    ys[2] = (int'(y) == HEIGHT_PIXELS - 1) ? 0 : int'(y) + 1;
    bank_addr = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        bank_addr[pixel_bank(xs[j], ys[i])] = ADDR_WIDTH'(pixel_addr(xs[j], ys[i], WIDTH_BLOCKS));
    center_onehot = '0;
    center_onehot[pixel_bank(xs[1], ys[1])] = 1'b1;
    center_addr = ADDR_WIDTH'(pixel_addr(xs[1], ys[1], WIDTH_BLOCKS));
  end
endmodule

// File: rtl/generation_sequencer.sv
// Walks one generation pixel by pixel: 9-bank neighbourhood reads, then the centre write one
// cycle later, then a drain/swap tail that flips the frame buffer pairing.
module generation_sequencer
  import conway_pkg::*;
#(
  parameter int WIDTH_PIXELS  = 6,
  parameter int HEIGHT_PIXELS = 6,
  parameter int WIDTH_BLOCKS  = 2,
  parameter int HEIGHT_BLOCKS = 2,
  parameter int ADDR_WIDTH    = 2,
  parameter int GEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [GEN_WIDTH-1:0]  generation_count,
  output logic [8:0]            read_enable,
  output logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [ADDR_WIDTH-1:0] read_addr_3,
  output logic [ADDR_WIDTH-1:0] read_addr_4,
  output logic [ADDR_WIDTH-1:0] read_addr_5,
  output logic [ADDR_WIDTH-1:0] read_addr_6,
  output logic [ADDR_WIDTH-1:0] read_addr_7,
  output logic [ADDR_WIDTH-1:0] read_addr_8,
  output logic [8:0]            write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [8:0]            center_select,
  output logic                  frame_buffer_select
);
  localparam int XW = (WIDTH_PIXELS  > 1) ? $clog2(WIDTH_PIXELS)  : 1;
  localparam int YW = (HEIGHT_PIXELS > 1) ? $clog2(HEIGHT_PIXELS) : 1;

  if (WIDTH_BLOCKS * HEIGHT_BLOCKS > (1 << ADDR_WIDTH)) begin : g_addr_width_too_small
    $error("ADDR_WIDTH too small for the block count");
  end

  state_e                                state_q, state_d;
  logic [XW-1:0]                         x_q, x_d;
  logic [YW-1:0]                         y_q, y_d;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  nb_addr, read_addr_q, read_addr_d;
  logic [NUM_BANKS-1:0]                  nb_center, rd_center_q, rd_center_d;
  logic [ADDR_WIDTH-1:0]                 nb_caddr, rd_caddr_q, rd_caddr_d;
  logic [8:0]                            read_enable_q, read_enable_d;
  logic [8:0]                            write_enable_q, write_enable_d;
  logic [8:0]                            center_select_q, center_select_d;
  logic [ADDR_WIDTH-1:0]                 write_addr_q, write_addr_d;
  logic                                  busy_q, busy_d, done_q, done_d, fbs_q, fbs_d;
  logic [GEN_WIDTH-1:0]                  gen_count_q, gen_count_d;
  logic                                  scan_next;

  // Addresses are generated for the pixel the counters move to, so the registered read
  // strobes line up with the cycle that pixel is in SCAN.
  neighbourhood_addr_gen #(
    .WIDTH_PIXELS (WIDTH_PIXELS),
    .HEIGHT_PIXELS(HEIGHT_PIXELS),
    .WIDTH_BLOCKS (WIDTH_BLOCKS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .XW           (XW),
    .YW           (YW)
  ) u_addr_gen (
    .x            (x_d),
    .y            (y_d),
    .bank_addr    (nb_addr),
    .center_onehot(nb_center),
    .center_addr  (nb_caddr)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE:  if (start) state_d = SCAN;
      SCAN: begin
        if (x_q == XW'(WIDTH_PIXELS - 1)) begin
          x_d = '0;
          if (y_q == YW'(HEIGHT_PIXELS - 1)) begin
            y_d     = '0;
            state_d = DRAIN;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      DRAIN: state_d = SWAP;
      SWAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    scan_next       = (state_d == SCAN);
    read_enable_d   = scan_next ? 9'h1FF : 9'h000;
    read_addr_d     = scan_next ? nb_addr : read_addr_q;
    rd_center_d     = scan_next ? nb_center : '0;
    rd_caddr_d      = scan_next ? nb_caddr : rd_caddr_q;
    // Write trails the read by one cycle to meet the BRAM data coming back.
    write_enable_d  = rd_center_q;
    center_select_d = rd_center_q;
    write_addr_d    = read_enable_q[0] ? rd_caddr_q : write_addr_q;
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == SWAP);
    gen_count_d     = gen_count_q + GEN_WIDTH'(state_d == SWAP);
    fbs_d           = fbs_q ^ (state_q == SWAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      x_q             <= '0;
      y_q             <= '0;
      read_addr_q     <= '0;
      rd_center_q     <= '0;
      rd_caddr_q      <= '0;
      read_enable_q   <= '0;
      write_enable_q  <= '0;
      center_select_q <= '0;
      write_addr_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      gen_count_q     <= '0;
      fbs_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      read_addr_q     <= read_addr_d;
      rd_center_q     <= rd_center_d;
      rd_caddr_q      <= rd_caddr_d;
      read_enable_q   <= read_enable_d;
      write_enable_q  <= write_enable_d;
      center_select_q <= center_select_d;
      write_addr_q    <= write_addr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      gen_count_q     <= gen_count_d;
      fbs_q           <= fbs_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign generation_count    = gen_count_q;
  assign read_enable         = read_enable_q;
  assign read_addr_0         = read_addr_q[0];
  assign read_addr_1         = read_addr_q[1];
  assign read_addr_2         = read_addr_q[2];
  assign read_addr_3         = read_addr_q[3];
  assign read_addr_4         = read_addr_q[4];
  assign read_addr_5         = read_addr_q[5];
  assign read_addr_6         = read_addr_q[6];
  assign read_addr_7         = read_addr_q[7];
  assign read_addr_8         = read_addr_q[8];
  assign write_enable        = write_enable_q;
  assign write_addr          = write_addr_q;
  assign center_select       = center_select_q;
  assign frame_buffer_select = fbs_q;
endmodule
